// File: rtl/counter_bank_if.sv
// Control/status bundle for counter_bank: the master drives the count controls,
// the slave (the counter bank) returns counter values and terminal-count flags.
interface counter_bank_if #(
  parameter int NCH   = 2,
  parameter int WIDTH = 4
);
  logic                 enable;
  logic [NCH-1:0]       ch_en;
  logic [NCH-1:0]       dir;
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] load_val;
  logic [NCH*WIDTH-1:0] out;
  logic [NCH-1:0]       tc;
  logic [NCH-1:0]       msb;

  modport master (
    output enable, ch_en, dir, load, load_val,
    input  out, tc, msb
  );

  modport slave (
    input  enable, ch_en, dir, load, load_val,
    output out, tc, msb
  );
endinterface

// File: rtl/counter_bank.sv
// Bank of NCH up/down counters with per-channel load, wrap or saturate at the
// terminal value, registered terminal-count pulses and optional carry cascading.
module counter_bank #(
  parameter int NCH      = 2,
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0,
  parameter int CASCADE  = 0
) (
`ifdef USE_POWER_PINS
  inout wire            vccd1,
  inout wire            vssd1,
`endif
  input  logic          clk,
  input  logic          reset,
  counter_bank_if.slave bus
);

  logic [WIDTH-1:0]     cnt_q [NCH];
  logic [WIDTH-1:0]     cnt_d [NCH];
  logic [NCH-1:0]       tc_q;
  logic [NCH-1:0]       tc_d;
  logic [NCH-1:0]       at_term;
  logic [NCH-1:0]       step;
  logic [NCH-1:0]       carry;
  logic [NCH*WIDTH-1:0] out_flat;
  logic [NCH-1:0]       msb_flat;

  // The carry ripples from channel 0 upward within one cycle; a load on a
  // channel kills its carry so higher channels do not step that cycle.
  always_comb begin : next_state
    logic ripple;
    ripple = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      at_term[i] = bus.dir[i] ? (cnt_q[i] == {WIDTH{1'b1}}) : (cnt_q[i] == '0);
      step[i]    = bus.enable & bus.ch_en[i] & ((CASCADE == 0) | ripple);
      carry[i]   = step[i] & at_term[i] & ~bus.load[i];
      ripple     = carry[i];
      tc_d[i]    = carry[i];
      cnt_d[i]   = cnt_q[i];
      if (bus.load[i]) begin
        cnt_d[i] = bus.load_val[i*WIDTH +: WIDTH];
      end else if (step[i] && !(at_term[i] && (SATURATE != 0))) begin
        cnt_d[i] = bus.dir[i] ? cnt_q[i] + WIDTH'(1) : cnt_q[i] - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      tc_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      tc_q <= tc_d;
    end
  end

  always_comb begin
    out_flat = '0;
    msb_flat = '0;
    for (int i = 0; i < NCH; i++) begin
      out_flat[i*WIDTH +: WIDTH] = cnt_q[i];
      msb_flat[i]                = cnt_q[i][WIDTH-1];
    end
  end

  assign bus.out = out_flat;
  assign bus.msb = msb_flat;
  assign bus.tc  = tc_q;

endmodule
